// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - shared widths, op codes and FSM states for spi_master_ctrl
package spi_master_ctrl_pkg;

    localparam int W_SPI = 8;

    typedef enum logic [1:0] {
        SPI_OP_NOP   = 2'b00,
        SPI_OP_WRITE = 2'b01,
        SPI_OP_READ  = 2'b10,
        SPI_OP_XCHG  = 2'b11
    } spi_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } spi_state_e;

    function automatic logic op_returns_data(spi_op_e op);
        return (op == SPI_OP_READ) || (op == SPI_OP_XCHG);
    endfunction

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// rtl/spi_master_ctrl_clk_div.sv - half-period divider producing a one-cycle tick every CLK_DIV clocks
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tick_o  = at_last && !clr_i;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || at_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode-0 single-byte SPI master; SPI_LOOPBACK_EN samples mosi instead of miso
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    input  logic [1:0]       cmd_op_i,
    input  logic [W_SPI-1:0] cmd_wdata_i,
    output logic             cmd_ready_o,
    output logic             busy_o,
    output logic             rsp_valid_o,
    output logic [W_SPI-1:0] rsp_data_o,
    output logic             sclk_o,
    output logic             cs_n_o,
    output logic             mosi_o,
    input  logic             miso_i
);

    spi_state_e       state_q, state_d;
    spi_op_e          op_q, op_d;
    logic [W_SPI-1:0] tx_q, tx_d;
    logic [W_SPI-1:0] rx_q, rx_d;
    logic [W_SPI-1:0] rsp_q, rsp_d;
    logic [2:0]       bit_q, bit_d;
    logic             phase_q, phase_d;
    logic             last_q, last_d;
    logic             tick;
    logic             sample_bit;
    spi_op_e          cmd_op;

    assign cmd_op = spi_op_e'(cmd_op_i);

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign sample_bit  = tx_q[W_SPI-1];
`else
    assign sample_bit  = miso_i;
`endif

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == ST_IDLE),
        .tick_o (tick)
    );

    assign busy_o     = (state_q != ST_IDLE);
    assign rsp_data_o = rsp_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_d       = rsp_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        last_d      = last_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        cs_n_o      = 1'b1;
        sclk_o      = 1'b0;
        mosi_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i && (cmd_op != SPI_OP_NOP)) begin
                    tx_d    = (cmd_op == SPI_OP_READ) ? '0 : cmd_wdata_i;
                    op_d    = cmd_op;
                    rx_d    = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cs_n_o = 1'b0;
                mosi_o = tx_q[W_SPI-1];
                if (tick) begin
                    // leaving SETUP is the first sclk rise
                    rx_d    = {rx_q[W_SPI-2:0], sample_bit};
                    phase_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cs_n_o = 1'b0;
                sclk_o = !phase_q;
                mosi_o = tx_q[W_SPI-1];
                if (tick) begin
                    if (!phase_q) begin
                        tx_d    = {tx_q[W_SPI-2:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        last_d  = (bit_q == 3'd7);
                        phase_d = 1'b1;
                    end else begin
                        // end of a low half: either the next rise or, after the 8th fall, the end of the frame
                        phase_d = 1'b0;
                        if (last_q) begin
                            if (op_returns_data(op_q)) begin
                                rsp_d = rx_q;
                            end
                            state_d = ST_DONE;
                        end else begin
                            rx_d = {rx_q[W_SPI-2:0], sample_bit};
                        end
                    end
                end
            end
            ST_DONE: begin
                rsp_valid_o = op_returns_data(op_q);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= SPI_OP_NOP;
            tx_q    <= '0;
            rx_q    <= '0;
            rsp_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rsp_q   <= rsp_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            last_q  <= last_d;
        end
    end

endmodule
